// File: rtl/e_io_filt_bank_if.sv
// Pad-side and fabric-side data bundle for one east-edge IO bank.
// The master side drives pads/fabric data in; the slave side (the bank) drives results out.
interface e_io_filt_bank_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0] from_fabric;
  logic [NUM_CH-1:0] to_fabric;
  logic [NUM_CH-1:0] pad_in;
  logic [NUM_CH-1:0] pad_out;
  logic [NUM_CH-1:0] pad_oe;
  logic [NUM_CH-1:0] edge_event;

  modport master (
    output from_fabric,
    output pad_in,
    input  to_fabric,
    input  pad_out,
    input  pad_oe,
    input  edge_event
  );

  modport slave (
    input  from_fabric,
    input  pad_in,
    output to_fabric,
    output pad_out,
    output pad_oe,
    output edge_event
  );
endinterface

// File: rtl/e_io_filt_bank.sv
// East-edge IO bank: per-channel direction, optional 2-flop sync, glitch filter,
// output register and registered edge-event pulse on the input-path value.
module e_io_filt_bank #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CFG_PER_CH    = 4
) (
  input  logic                         UserCLK,
  input  logic                         resetn,
  input  logic [NUM_CH*CFG_PER_CH-1:0] ConfigBits,
  e_io_filt_bank_if.slave              io
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  logic [NUM_CH-1:0] dir, sync_en, filt_en, oreg_en;
  logic [NUM_CH-1:0] s1_q, s2_q;
  logic [NUM_CH-1:0] filt_q, filt_d;
  logic [NUM_CH-1:0] prev_q, oreg_q;
  logic [NUM_CH-1:0] edge_q, edge_d;
  logic [NUM_CH-1:0] sync_val, in_val;
  logic [CntW-1:0]   cnt_q [NUM_CH];
  logic [CntW-1:0]   cnt_d [NUM_CH];

  always_comb begin
    dir      = '0;
    sync_en  = '0;
    filt_en  = '0;
    oreg_en  = '0;
    sync_val = '0;
    in_val   = '0;
    filt_d   = filt_q;
    edge_d   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      dir[c]     = ConfigBits[CFG_PER_CH*c + 0];
      sync_en[c] = ConfigBits[CFG_PER_CH*c + 1];
      filt_en[c] = ConfigBits[CFG_PER_CH*c + 2];
      oreg_en[c] = ConfigBits[CFG_PER_CH*c + 3];

      sync_val[c] = sync_en[c] ? s2_q[c] : io.pad_in[c];
      cnt_d[c]    = cnt_q[c];

      // A sample equal to the settled state restarts the run of differing samples.
      if (!filt_en[c]) begin
        filt_d[c] = sync_val[c];
        cnt_d[c]  = '0;
      end else if (sync_val[c] == filt_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CntMax) begin
        filt_d[c] = sync_val[c];
        cnt_d[c]  = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + CntW'(1);
      end

      in_val[c] = filt_en[c] ? filt_q[c] : sync_val[c];
      edge_d[c] = (in_val[c] != prev_q[c]) & ~dir[c];
    end
  end

  // Input-path state keeps running in output mode; only the outputs are masked.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      prev_q <= '0;
      oreg_q <= '0;
      edge_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      s1_q   <= io.pad_in;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      prev_q <= in_val;
      oreg_q <= io.from_fabric;
      edge_q <= edge_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign io.to_fabric  = ~dir & in_val;
  assign io.pad_out    = dir & ((oreg_en & oreg_q) | (~oreg_en & io.from_fabric));
  assign io.pad_oe     = dir;
  assign io.edge_event = edge_q;

endmodule

// File: tb/tb_e_io_filt_bank.sv
// Scoreboard bench for e_io_filt_bank: stimulus pushes model predictions, a monitor
// pops and compares once per cycle between clock edges.
module tb_e_io_filt_bank;
  localparam int N  = 4;
  localparam int FC = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N*4-1:0] cfg;

  e_io_filt_bank_if #(.NUM_CH(N)) io ();

  e_io_filt_bank #(
    .NUM_CH       (N),
    .FILTER_CYCLES(FC),
    .CFG_PER_CH   (4)
  ) dut (
    .UserCLK   (clk),
    .resetn    (rstn),
    .ConfigBits(cfg),
    .io        (io)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] to;
    logic [N-1:0] po;
    logic [N-1:0] oe;
    logic [N-1:0] ev;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: sync is a two-deep sample history, the filter a run length of
  // consecutive samples disagreeing with the settled value.
  bit m_hist1[N], m_hist2[N], m_settled[N], m_last_in[N], m_oreg[N], m_ev[N];
  int m_run[N];

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_hist1[c] = 0; m_hist2[c] = 0; m_settled[c] = 0;
      m_last_in[c] = 0; m_oreg[c] = 0; m_ev[c] = 0; m_run[c] = 0;
    end
  endfunction

  function automatic bit sample_of(int c, logic [N-1:0] pin);
    return cfg[4*c+1] ? m_hist2[c] : pin[c];
  endfunction

  function automatic bit input_of(int c, logic [N-1:0] pin);
    return cfg[4*c+2] ? m_settled[c] : sample_of(c, pin);
  endfunction

  function automatic exp_t model_out(logic [N-1:0] pin, logic [N-1:0] ff);
    exp_t e;
    for (int c = 0; c < N; c++) begin
      bit is_out;
      is_out  = cfg[4*c];
      e.to[c] = is_out ? 1'b0 : input_of(c, pin);
      e.po[c] = is_out ? (cfg[4*c+3] ? m_oreg[c] : ff[c]) : 1'b0;
      e.oe[c] = is_out;
      e.ev[c] = m_ev[c];
    end
    return e;
  endfunction

  function automatic void model_step(logic [N-1:0] pin, logic [N-1:0] ff);
    for (int c = 0; c < N; c++) begin
      bit s, v;
      s = sample_of(c, pin);
      v = input_of(c, pin);
      m_ev[c]      = (v != m_last_in[c]) && !cfg[4*c];
      m_last_in[c] = v;
      m_oreg[c]    = ff[c];
      if (!cfg[4*c+2]) begin
        m_settled[c] = s;
        m_run[c]     = 0;
      end else if (s == m_settled[c]) begin
        m_run[c] = 0;
      end else begin
        m_run[c]++;
        if (m_run[c] >= FC) begin
          m_settled[c] = s;
          m_run[c]     = 0;
        end
      end
      m_hist2[c] = m_hist1[c];
      m_hist1[c] = pin[c];
    end
  endfunction

  // One stimulus cycle: drive mid-cycle, predict, then advance model across next edge.
  task automatic apply(input logic [N*4-1:0] c_in, input logic [N-1:0] pin,
                       input logic [N-1:0] ff, input logic rn);
    @(negedge clk);
    #1;
    cfg = c_in;
    io.pad_in = pin;
    io.from_fabric = ff;
    rstn = rn;
    if (!rn) model_reset();
    sbq.push_back(model_out(pin, ff));
    if (rn) model_step(pin, ff);
  endtask

  initial begin : monitor
    exp_t e;
    bit   bad;
    forever begin
      @(negedge clk);
      #3;
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        bad = 0;
        n_vec++;
        if (io.to_fabric !== e.to) begin
          bad = 1;
          $display("FAIL vec%0d to_fabric: got %b want %b", n_vec, io.to_fabric, e.to);
        end
        if (io.pad_out !== e.po) begin
          bad = 1;
          $display("FAIL vec%0d pad_out: got %b want %b", n_vec, io.pad_out, e.po);
        end
        if (io.pad_oe !== e.oe) begin
          bad = 1;
          $display("FAIL vec%0d pad_oe: got %b want %b", n_vec, io.pad_oe, e.oe);
        end
        if (io.edge_event !== e.ev) begin
          bad = 1;
          $display("FAIL vec%0d edge_event: got %b want %b", n_vec, io.edge_event, e.ev);
        end
        if (bad) n_bad++;
      end
    end
  end

  localparam logic [N*4-1:0] CfgSf  = {N{4'b0110}};
  localparam logic [N*4-1:0] CfgOut = {N{4'b1001}};
  localparam logic [N*4-1:0] CfgByp = '0;

  initial begin : stim
    logic [N*4-1:0] rc;
    rstn = 1'b0;
    cfg  = CfgSf;
    io.pad_in = '1;
    io.from_fabric = '0;
    model_reset();

    // Reset with pads high, then release and let the filter settle.
    repeat (3)  apply(CfgSf, '1, '0, 1'b0);
    repeat (10) apply(CfgSf, '1, '0, 1'b1);

    // Glitch rejection: 3-sample pulse is dropped, 4-sample pulse passes.
    repeat (10) apply(CfgSf, '0, '0, 1'b1);
    repeat (3)  apply(CfgSf, '1, '0, 1'b1);
    repeat (10) apply(CfgSf, '0, '0, 1'b1);
    repeat (4)  apply(CfgSf, '1, '0, 1'b1);
    repeat (12) apply(CfgSf, '0, '0, 1'b1);

    // Output mode with registered output while pads toggle.
    repeat (2) apply(CfgOut, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) apply(CfgOut, (i % 2) ? '1 : '0, '1, 1'b1);
    apply(CfgOut, '1, '0, 1'b1);

    // Full bypass: combinational follow plus edge pulses.
    for (int i = 0; i < 6; i++) apply(CfgByp, (i % 2) ? '0 : '1, '0, 1'b1);

    // Async reset between edges while the filter is two samples into a count.
    repeat (10) apply(CfgSf, '1, '0, 1'b1);
    repeat (4)  apply(CfgSf, '0, '0, 1'b1);
    repeat (2)  apply(CfgSf, '0, '0, 1'b0);
    repeat (10) apply(CfgSf, '1, '0, 1'b1);

    // Mixed fixed roles per channel with random pads.
    for (int i = 0; i < 1000; i++) begin
      rc = {4'b0000, 4'b0110, 4'b0010, 1'($urandom_range(0, 1)), 3'b001};
      apply(rc, N'($urandom), N'($urandom), 1'b1);
    end

    // Random configs changing on the fly, with one reset pulse.
    rc = N*4'($urandom);
    for (int i = 0; i < 300; i++) begin
      if (i % 20 == 0) rc = N*4'($urandom);
      apply(rc, N'($urandom), N'($urandom), (i >= 150 && i < 152) ? 1'b0 : 1'b1);
    end

    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
